// File: rtl/rip_const.sv
// Shared constants and state encodings for the rip memory front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rip_const;

  // Bits per byte; all strobe/line arithmetic is expressed in these units.
  localparam int B_WIDTH = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_WAIT = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } r_state_e;

  // $clog2 that never returns 0, so index vectors stay at least 1 bit wide.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rip_round_robin_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer.
// Latency: grant is combinational from req; pointer updates on the edge where advance=1 and any req.
// Backpressure: holding advance low freezes the pointer; the grant just follows req.
// Ports: req (N requesters), advance (consume current grant), grant (one-hot), grant_idx (binary).
module rip_round_robin_arbiter
  import rip_const::*;
#(
  parameter int N = 2,
  localparam int IW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // Pointer holds the first channel to consider, i.e. one past the last grant.
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic [IW-1:0] ptr_nxt;
  logic          hit;
  int            j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    hit       = 1'b0;
    j         = 0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (!hit && req[cand]) begin
        hit       = 1'b1;
        grant     = '0;
        grant[cand] = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_nxt = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance && hit) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/rip_memory_port_arbiter.sv
// Multi-channel CPU front end onto the line-wide read/write ports of rip_axi_master.
// Latency: request edge t -> busy at t+1, valid at t+2 when the engine is idle; busy clears the edge after done.
// Backpressure: valid holds until ready; channel inputs are ignored while busy; one outstanding per engine.
// Ports: we/re/addr/din per channel in, dout/busy per channel out;
//        waddr/wdata/wstrb/wvalid/wready/wdone write port; raddr/rvalid/rready/rdata/rdone read port.
module rip_memory_port_arbiter
  import rip_const::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 4
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [NUM_CH*(DATA_WIDTH/B_WIDTH)-1:0]  we,
  input  logic [NUM_CH-1:0]                       re,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]            addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]            din,
  output logic [NUM_CH*DATA_WIDTH-1:0]            dout,
  output logic [NUM_CH-1:0]                       busy,
  input  logic                                    wready,
  output logic [ADDR_WIDTH-1:0]                   waddr,
  output logic [LINE_SIZE*B_WIDTH-1:0]            wdata,
  output logic [LINE_SIZE-1:0]                    wstrb,
  output logic                                    wvalid,
  input  logic                                    wdone,
  input  logic                                    rready,
  output logic [ADDR_WIDTH-1:0]                   raddr,
  output logic                                    rvalid,
  input  logic [LINE_SIZE*B_WIDTH-1:0]            rdata,
  input  logic                                    rdone
);

  localparam int STRB_W         = DATA_WIDTH / B_WIDTH;
  localparam int WORDS_PER_LINE = LINE_SIZE / STRB_W;
  localparam int OFF_W          = clog2_min1(WORDS_PER_LINE);
  localparam int CH_W           = clog2_min1(NUM_CH);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [STRB_W-1:0]     strb;
  } req_t;

  function automatic logic [ADDR_WIDTH-1:0] line_of(input logic [ADDR_WIDTH-1:0] a);
    return a & ~ADDR_WIDTH'(LINE_SIZE - 1);
  endfunction

  // Word slot of the addressed data word inside its line.
  function automatic logic [OFF_W-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return OFF_W'(int'(a & ADDR_WIDTH'(LINE_SIZE - 1)) / STRB_W);
  endfunction

  req_t              req_q [NUM_CH];
  logic [NUM_CH-1:0] w_pend, r_pend;
  logic [NUM_CH-1:0] w_gnt, r_gnt;
  logic [CH_W-1:0]   w_gidx, r_gidx;
  logic [NUM_CH-1:0] w_sel, r_sel;   // one-hot owner of the in-flight transaction
  req_t              w_win, r_win;

  w_state_e w_state, w_state_nxt;
  r_state_e r_state, r_state_nxt;

  logic w_done_fire, r_done_fire;
  assign w_done_fire = (w_state == W_WAIT) && wdone;
  assign r_done_fire = (r_state == R_WAIT) && rdone;

  // Per-channel request capture and completion.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy <= '0;
      for (int i = 0; i < NUM_CH; i++) req_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!busy[i]) begin
          if ((|we[i*STRB_W +: STRB_W]) || re[i]) begin
            busy[i]  <= 1'b1;
            // A simultaneous re is dropped: the request becomes a write.
            req_q[i] <= '{wr:   |we[i*STRB_W +: STRB_W],
                          addr: addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                          din:  din[i*DATA_WIDTH +: DATA_WIDTH],
                          strb: we[i*STRB_W +: STRB_W]};
          end
        end else if ((w_done_fire && w_sel[i]) || (r_done_fire && r_sel[i])) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // A read to the line of the in-flight write waits until the write engine is back in idle.
  always_comb begin
    w_pend = '0;
    r_pend = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pend[i] = busy[i] & req_q[i].wr;
      r_pend[i] = busy[i] & ~req_q[i].wr &
                  ~((w_state != W_IDLE) && (line_of(req_q[i].addr) == waddr));
    end
  end

  rip_round_robin_arbiter #(.N(NUM_CH)) u_w_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (w_pend),
    .advance   (w_state == W_IDLE),
    .grant     (w_gnt),
    .grant_idx (w_gidx)
  );

  rip_round_robin_arbiter #(.N(NUM_CH)) u_r_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (r_pend),
    .advance   (r_state == R_IDLE),
    .grant     (r_gnt),
    .grant_idx (r_gidx)
  );

  assign w_win = req_q[w_gidx];
  assign r_win = req_q[r_gidx];

  // ---------------- write engine ----------------
  always_ff @(posedge clk) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (|w_pend) w_state_nxt = W_REQ;
      W_REQ:   if (wready)  w_state_nxt = W_WAIT;
      W_WAIT:  if (wdone)   w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wvalid <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      wstrb  <= '0;
      w_sel  <= '0;
    end else if (w_state == W_IDLE && |w_pend) begin
      wvalid <= 1'b1;
      w_sel  <= w_gnt;
      waddr  <= line_of(w_win.addr);
      wdata  <= {WORDS_PER_LINE{w_win.din}};
      wstrb  <= LINE_SIZE'(w_win.strb) << (int'(word_of(w_win.addr)) * STRB_W);
    end else if (w_state == W_REQ && wready) begin
      wvalid <= 1'b0;
    end
  end

  // ---------------- read engine ----------------
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (|r_pend) r_state_nxt = R_REQ;
      R_REQ:   if (rready)  r_state_nxt = R_WAIT;
      R_WAIT:  if (rdone)   r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rvalid <= 1'b0;
      raddr  <= '0;
      r_sel  <= '0;
    end else if (r_state == R_IDLE && |r_pend) begin
      rvalid <= 1'b1;
      r_sel  <= r_gnt;
      raddr  <= line_of(r_win.addr);
    end else if (r_state == R_REQ && rready) begin
      rvalid <= 1'b0;
    end
  end

  // dout lands on the same edge busy clears.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout <= '0;
    end else if (r_done_fire) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_sel[i]) begin
          dout[i*DATA_WIDTH +: DATA_WIDTH] <=
            rdata[int'(word_of(req_q[i].addr))*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_rip_memory_port_arbiter.sv
module tb_rip_memory_port_arbiter;

  logic clk;
  logic rstn;

  // Main DUT: NUM_CH=2, LINE_SIZE=4
  logic [7:0]  we;
  logic [1:0]  re;
  logic [63:0] addr, din, dout;
  logic [1:0]  busy;
  logic        wready, wvalid, wdone, rready, rvalid, rdone;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic [3:0]  wstrb;

  // Second DUT: NUM_CH=1, LINE_SIZE=8
  logic [3:0]  we8;
  logic        re8;
  logic [31:0] addr8, din8, dout8;
  logic        busy8;
  logic        wready8, wvalid8, wdone8, rready8, rvalid8, rdone8;
  logic [31:0] waddr8, raddr8;
  logic [63:0] wdata8, rdata8;
  logic [7:0]  wstrb8;

  rip_memory_port_arbiter dut (
    .clk(clk), .rstn(rstn), .we(we), .re(re), .addr(addr), .din(din),
    .dout(dout), .busy(busy), .wready(wready), .waddr(waddr), .wdata(wdata),
    .wstrb(wstrb), .wvalid(wvalid), .wdone(wdone), .rready(rready),
    .raddr(raddr), .rvalid(rvalid), .rdata(rdata), .rdone(rdone)
  );

  rip_memory_port_arbiter #(.NUM_CH(1), .LINE_SIZE(8)) dut8 (
    .clk(clk), .rstn(rstn), .we(we8), .re(re8), .addr(addr8), .din(din8),
    .dout(dout8), .busy(busy8), .wready(wready8), .waddr(waddr8), .wdata(wdata8),
    .wstrb(wstrb8), .wvalid(wvalid8), .wdone(wdone8), .rready(rready8),
    .raddr(raddr8), .rvalid(rvalid8), .rdata(rdata8), .rdone(rdone8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wexp_t;

  wexp_t       wr_q[$];
  logic [31:0] rd_q[$];
  int          wdone_dly = 1;
  int          rdone_dly = 3;

  // Write-side responder: checks each accepted request against the scoreboard, then pulses wdone.
  initial begin
    wexp_t e;
    wdone = 1'b0;
    forever begin
      @(negedge clk);
      if (wvalid && wready) begin
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("wr_addr", 64'(waddr), 64'(e.a));
          chk("wr_data", 64'(wdata), 64'(e.d));
          chk("wr_strb", 64'(wstrb), 64'(e.s));
        end else begin
          chk("wr_unexpected", 64'(waddr), 64'hFFFF_FFFF);
        end
        @(posedge clk);
        repeat (wdone_dly) @(negedge clk);
        wdone = 1'b1;
        @(negedge clk);
        wdone = 1'b0;
      end
    end
  end

  // Read-side responder: checks each accepted address, then returns rd_fn(addr) with rdone.
  initial begin
    logic [31:0] a;
    rdone = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (rvalid && rready) begin
        a = raddr;
        if (rd_q.size() > 0) chk("rd_addr", 64'(raddr), 64'(rd_q.pop_front()));
        else                 chk("rd_unexpected", 64'(raddr), 64'hFFFF_FFFF);
        @(posedge clk);
        repeat (rdone_dly) @(negedge clk);
        rdata = rd_fn(a);
        rdone = 1'b1;
        @(negedge clk);
        rdone = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free(input int ch);
    int n;
    n = 0;
    while (busy[ch] && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("free_ch%0d", ch), 64'(busy[ch]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int early;
    int seen;

    rstn = 1'b0;
    we = '0; re = '0; addr = '0; din = '0;
    wready = 1'b1; rready = 1'b1;
    we8 = '0; re8 = 1'b0; addr8 = '0; din8 = '0;
    wready8 = 1'b1; rready8 = 1'b1; wdone8 = 1'b0; rdone8 = 1'b0; rdata8 = '0;
    tick(); tick();

    // ---- reset state ----
    chk("rst_dout",   64'(dout),   64'd0);
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_waddr",  64'(waddr),  64'd0);
    chk("rst_wdata",  64'(wdata),  64'd0);
    chk("rst_wstrb",  64'(wstrb),  64'd0);
    chk("rst_raddr",  64'(raddr),  64'd0);
    rstn = 1'b1;
    tick();

    // ---- single write ----
    wdone_dly = 1;
    wr_q.push_back('{32'h100, 32'hDEAD_BEEF, 4'hF});
    we[3:0] = 4'hF; addr[31:0] = 32'h100; din[31:0] = 32'hDEAD_BEEF;
    tick();
    chk("w1_busy_t1",   64'(busy[0]), 64'd1);
    chk("w1_wvalid_t1", 64'(wvalid),  64'd0);
    we = '0;
    tick();
    chk("w1_wvalid_t2", 64'(wvalid), 64'd1);
    begin
      int n;
      n = 0;
      while (busy[0] && n < 50) begin tick(); n++; end
    end
    chk("w1_busy_clr",       64'(busy[0]), 64'd0);
    chk("w1_clr_after_wdone", 64'(wdone),  64'd1);

    // ---- round robin: both channels, then pointer moved by a lone ch0 read ----
    rdone_dly = 3;
    rd_q.push_back(32'h10); rd_q.push_back(32'h20);
    re = 2'b11; addr = {32'h20, 32'h10};
    tick();
    re = '0;
    wait_free(0); wait_free(1);
    chk("rr1_dout0", 64'(dout[31:0]),  64'(rd_fn(32'h10)));
    chk("rr1_dout1", 64'(dout[63:32]), 64'(rd_fn(32'h20)));

    rd_q.push_back(32'h30);
    re = 2'b01; addr[31:0] = 32'h30;
    tick();
    re = '0;
    wait_free(0);
    chk("rr_lone_dout0", 64'(dout[31:0]), 64'(rd_fn(32'h30)));

    rd_q.push_back(32'h20); rd_q.push_back(32'h10);
    re = 2'b11; addr = {32'h20, 32'h10};
    tick();
    re = '0;
    wait_free(0); wait_free(1);
    chk("rr2_dout0", 64'(dout[31:0]),  64'(rd_fn(32'h10)));
    chk("rr2_dout1", 64'(dout[63:32]), 64'(rd_fn(32'h20)));

    // ---- read-after-write hazard on the same line ----
    wdone_dly = 10;
    wr_q.push_back('{32'h40, 32'h0102_0304, 4'hF});
    we[3:0] = 4'hF; addr[31:0] = 32'h40; din[31:0] = 32'h0102_0304;
    tick();
    we = '0;
    rd_q.push_back(32'h40);
    re = 2'b10; addr[63:32] = 32'h40;
    tick();
    re = '0;
    early = 0; seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      tick();
      if (wdone) begin
        seen = 1;
        chk("raw_rvalid_at_wdone", 64'(rvalid), 64'd0);
        tick();
        chk("raw_rvalid_after_wdone", 64'(rvalid), 64'd1);
      end else if (rvalid) begin
        early++;
      end
    end
    chk("raw_no_early_read", 64'(early), 64'd0);
    chk("raw_wdone_seen",    64'(seen),  64'd1);
    wait_free(0); wait_free(1);
    chk("raw_dout1", 64'(dout[63:32]), 64'(rd_fn(32'h40)));

    // ---- different line: read issues while the write is in flight ----
    wr_q.push_back('{32'h40, 32'h0A0B_0C0D, 4'hF});
    we[3:0] = 4'hF; addr[31:0] = 32'h40; din[31:0] = 32'h0A0B_0C0D;
    tick();
    we = '0;
    rd_q.push_back(32'h80);
    re = 2'b10; addr[63:32] = 32'h80;
    tick();
    re = '0;
    tick();
    chk("conc_rvalid", 64'(rvalid),  64'd1);
    chk("conc_w_busy", 64'(busy[0]), 64'd1);
    wait_free(0); wait_free(1);
    chk("conc_dout1", 64'(dout[63:32]), 64'(rd_fn(32'h80)));

    // ---- read backpressure ----
    wdone_dly = 1;
    rready = 1'b0;
    rd_q.push_back(32'h60);
    re = 2'b01; addr[31:0] = 32'h60;
    tick();
    re = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rvalid_hold", 64'(rvalid), 64'd1);
      chk("bp_raddr_hold",  64'(raddr),  64'h60);
      if (k == 4) rready = 1'b1;
      tick();
    end
    chk("bp_rvalid_drop", 64'(rvalid), 64'd0);
    wait_free(0);
    chk("bp_dout0", 64'(dout[31:0]), 64'(rd_fn(32'h60)));

    // ---- write beats read on one channel; 8-byte line, single channel ----
    we8 = 4'h3; re8 = 1'b1; addr8 = 32'h202; din8 = 32'h1122_3344;
    tick();
    chk("x8_busy", 64'(busy8), 64'd1);
    we8 = '0; re8 = 1'b0;
    tick();
    chk("x8_wvalid", 64'(wvalid8), 64'd1);
    chk("x8_waddr",  64'(waddr8),  64'h200);
    chk("x8_wstrb",  64'(wstrb8),  64'h03);
    chk("x8_wdata",  wdata8,       64'h1122_3344_1122_3344);
    chk("x8_no_read", 64'(rvalid8), 64'd0);
    tick();
    chk("x8_wvalid_drop", 64'(wvalid8), 64'd0);
    wdone8 = 1'b1;
    tick();
    wdone8 = 1'b0;
    chk("x8_busy_clr", 64'(busy8), 64'd0);
    tick(); tick();
    chk("x8_no_read_late", 64'(rvalid8), 64'd0);

    we8 = 4'hF; addr8 = 32'h206; din8 = 32'hCAFE_F00D;
    tick();
    we8 = '0;
    tick();
    chk("x8_hi_wstrb", 64'(wstrb8), 64'hF0);
    chk("x8_hi_waddr", 64'(waddr8), 64'h200);
    tick();
    wdone8 = 1'b1;
    tick();
    wdone8 = 1'b0;
    chk("x8_hi_busy_clr", 64'(busy8), 64'd0);

    // ---- reset while the read engine waits for rdone ----
    rdone_dly = 6;
    rd_q.push_back(32'h90);
    re = 2'b10; addr[63:32] = 32'h90;
    tick();
    re = '0;
    tick();
    chk("mr_rvalid", 64'(rvalid), 64'd1);
    tick();
    chk("mr_in_wait_busy", 64'(busy[1]), 64'd1);
    rstn = 1'b0;
    tick();
    chk("mr_rvalid_rst", 64'(rvalid), 64'd0);
    chk("mr_busy_rst",   64'(busy),   64'd0);
    chk("mr_dout_rst",   64'(dout),   64'd0);
    rstn = 1'b1;
    repeat (12) tick();
    chk("mr_stale_dout", 64'(dout), 64'd0);
    chk("mr_stale_busy", 64'(busy), 64'd0);

    rdone_dly = 3;
    rd_q.push_back(32'hA0);
    re = 2'b01; addr[31:0] = 32'hA0;
    tick();
    re = '0;
    chk("mr_new_busy", 64'(busy[0]), 64'd1);
    tick();
    chk("mr_new_rvalid", 64'(rvalid), 64'd1);
    wait_free(0);
    chk("mr_new_dout0", 64'(dout[31:0]),  64'(rd_fn(32'hA0)));
    chk("mr_new_dout1", 64'(dout[63:32]), 64'd0);

    repeat (4) tick();
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
